// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard consumer: owns the PC, the IF/ID register and the ID/EX control word.
// Applies freeze, flush, load-use bubble and advance actions, and keeps saturating event counters.
module pipe_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CTRL_W    = 16,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              bubble,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              mem_busy,
    output logic [31:0]       pc,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc4,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        id_instr_q;
    logic [31:0]        id_pc4_q;
    logic [CTRL_W-1:0]  ex_ctrl_q;
    logic               ex_valid_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;
    logic [31:0]        pc4_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pc4_d = pc_q + 32'd4;

    // Priority: freeze beats flush beats bubble beats advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            id_instr_q  <= NOP_INSTR;
            id_pc4_q    <= RESET_PC + 32'd4;
            ex_ctrl_q   <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (mem_busy) begin
            state_q <= FREEZE;
        end else if (branch_taken) begin
            state_q     <= RUN;
            pc_q        <= branch_target;
            id_instr_q  <= NOP_INSTR;
            id_pc4_q    <= branch_target;
            ex_ctrl_q   <= '0;
            ex_valid_q  <= 1'b0;
            flush_cnt_q <= sat_inc(flush_cnt_q);
        end else if (bubble) begin
            state_q     <= STALL;
            ex_ctrl_q   <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end else begin
            state_q    <= RUN;
            pc_q       <= pc4_d;
            id_instr_q <= if_instr;
            id_pc4_q   <= pc4_d;
            ex_ctrl_q  <= id_ctrl;
            ex_valid_q <= 1'b1;
        end
    end

    assign pc        = pc_q;
    assign id_instr  = id_instr_q;
    assign id_pc4    = id_pc4_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign ex_valid  = ex_valid_q;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; a second, narrow-counter instance covers counter saturation.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instr;
    logic [15:0] id_ctrl;
    logic        bubble;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_busy;

    logic [31:0] pc, id_instr, id_pc4;
    logic [15:0] ex_ctrl;
    logic        ex_valid;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_pc, s_id_instr, s_id_pc4;
    logic [15:0] s_ex_ctrl;
    logic        s_ex_valid;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int nchecks = 0;
    int nerr    = 0;

    pipe_stall_ctrl dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .id_ctrl(id_ctrl), .bubble(bubble),
        .branch_taken(branch_taken), .branch_target(branch_target), .mem_busy(mem_busy),
        .pc(pc), .id_instr(id_instr), .id_pc4(id_pc4), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stall_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .if_instr(if_instr), .id_ctrl(id_ctrl), .bubble(bubble),
        .branch_taken(branch_taken), .branch_target(branch_target), .mem_busy(mem_busy),
        .pc(s_pc), .id_instr(s_id_instr), .id_pc4(s_id_pc4), .ex_ctrl(s_ex_ctrl),
        .ex_valid(s_ex_valid), .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                           input logic [31:0] e_pc4, input logic [15:0] e_ctrl, input logic e_vld,
                           input logic [1:0] e_st, input logic [15:0] e_sc, input logic [15:0] e_fc);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".id_instr"}, id_instr, e_ins);
        chk({tag, ".id_pc4"}, id_pc4, e_pc4);
        chk({tag, ".ex_ctrl"}, {16'h0, ex_ctrl}, {16'h0, e_ctrl});
        chk({tag, ".ex_valid"}, {31'h0, ex_valid}, {31'h0, e_vld});
        chk({tag, ".state"}, {30'h0, state}, {30'h0, e_st});
        chk({tag, ".stall_cnt"}, {16'h0, stall_cnt}, {16'h0, e_sc});
        chk({tag, ".flush_cnt"}, {16'h0, flush_cnt}, {16'h0, e_fc});
    endtask

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'hA000_000A; prog[1] = 32'hB000_000B;
        prog[2] = 32'hC000_000C; prog[3] = 32'hD000_000D;

        rst = 1'b1; if_instr = '0; id_ctrl = '0; bubble = 1'b0;
        branch_taken = 1'b0; branch_target = '0; mem_busy = 1'b0;
        #12;
        chk_all("reset", 32'h0, 32'h0, 32'h4, 16'h0, 1'b0, 2'd0, 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain advance through A..D
        for (int i = 0; i < 4; i++) begin
            if_instr = prog[i];
            id_ctrl  = 16'h0100 + 16'(i);
            step();
            chk_all($sformatf("adv%0d", i), 32'(4 * (i + 1)), prog[i], 32'(4 * (i + 1)),
                    16'h0100 + 16'(i), 1'b1, 2'd0, 16'd0, 16'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if_instr = 32'h1111_0000 + 32'(i);
            id_ctrl  = 16'h0200 + 16'(i);
            step();
        end
        chk_all("at20", 32'h20, 32'h1111_0003, 32'h20, 16'h0203, 1'b1, 2'd0, 16'd0, 16'd0);

        // Single load-use bubble
        bubble = 1'b1; if_instr = 32'h2222_2222; id_ctrl = 16'h0333;
        step();
        chk_all("stall", 32'h20, 32'h1111_0003, 32'h20, 16'h0, 1'b0, 2'd1, 16'd1, 16'd0);
        bubble = 1'b0;
        step();
        chk_all("resume", 32'h24, 32'h2222_2222, 32'h24, 16'h0333, 1'b1, 2'd0, 16'd1, 16'd0);

        // Branch wins over simultaneous bubble
        bubble = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
        step();
        chk_all("flush", 32'h100, 32'h0, 32'h100, 16'h0, 1'b0, 2'd0, 16'd1, 16'd1);
        bubble = 1'b0; branch_taken = 1'b0;
        if_instr = 32'h3333_3333; id_ctrl = 16'h0444;
        step();
        chk_all("postflush", 32'h104, 32'h3333_3333, 32'h104, 16'h0444, 1'b1, 2'd0, 16'd1, 16'd1);

        // Freeze with a pending bubble, then release
        mem_busy = 1'b1; bubble = 1'b1; if_instr = 32'h4444_4444; id_ctrl = 16'h0555;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("freeze%0d", i), 32'h104, 32'h3333_3333, 32'h104, 16'h0444,
                    1'b1, 2'd2, 16'd1, 16'd1);
        end
        mem_busy = 1'b0;
        step();
        chk_all("unfreeze", 32'h104, 32'h3333_3333, 32'h104, 16'h0, 1'b0, 2'd1, 16'd2, 16'd1);
        bubble = 1'b0;

        // PC wrap at top of address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0; if_instr = 32'h5555_5555; id_ctrl = 16'h0666;
        step();
        chk_all("wrap", 32'h0, 32'h5555_5555, 32'h0, 16'h0666, 1'b1, 2'd0, 16'd2, 16'd2);

        // Narrow counters saturate at 3 while wide ones keep counting
        bubble = 1'b1;
        step();
        chk("sat.stall1", {30'h0, s_stall_cnt}, 32'd3);
        step();
        chk("sat.stall2", {30'h0, s_stall_cnt}, 32'd3);
        chk("wide.stall", {16'h0, stall_cnt}, 32'd4);
        chk("stall2.state", {30'h0, state}, 32'd1);
        bubble = 1'b0; branch_taken = 1'b1; branch_target = 32'h180;
        step();
        chk("sat.flush1", {30'h0, s_flush_cnt}, 32'd3);
        branch_target = 32'h200;
        step();
        chk("sat.flush2", {30'h0, s_flush_cnt}, 32'd3);
        chk("wide.flush", {16'h0, flush_cnt}, 32'd4);
        branch_taken = 1'b0;

        // Asynchronous reset in the middle of a freeze
        mem_busy = 1'b1;
        step();
        chk("prefrz.state", {30'h0, state}, 32'd2);
        chk("prefrz.pc", pc, 32'h200);
        #3;
        rst = 1'b1;
        #1;
        chk_all("asyncrst", 32'h0, 32'h0, 32'h4, 16'h0, 1'b0, 2'd0, 16'd0, 16'd0);
        mem_busy = 1'b0; if_instr = 32'h6666_6666; id_ctrl = 16'h0777;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_all("afterrst", 32'h4, 32'h6666_6666, 32'h4, 16'h0777, 1'b1, 2'd0, 16'd0, 16'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
